// File: rtl/md_scheduler.sv
// md_scheduler: multiply/divide unit with HI/LO registers, busy timing and D-stage stall.
// Results are computed at accept and committed to HI/LO when the busy period ends.
module md_scheduler #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Req,
   input  logic        MD_D,
   output logic        Busy,
   output logic        Stall_MD,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam logic [1:0] IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2;
   localparam int MAXC = MULT_CYC > DIV_CYC ? MULT_CYC : DIV_CYC;
   localparam int CW = MAXC < 16 ? 4 : $clog2(MAXC + 1);
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   res_hi, res_lo;
   logic          res_ok;
   logic          accept, a_neg, b_neg;
   logic [31:0]   a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;
   logic [63:0]   prod;
   assign accept   = state == IDLE && Start && !Req;
   assign Busy     = state != IDLE;
   assign Stall_MD = MD_D && (Busy || (Start && !Req && !MDOp[2]));
   assign prod = MDOp[0] ? {32'b0, A} * {32'b0, B}
                         : {{32{A[31]}}, A} * {{32{B[31]}}, B};
   // Signed division on magnitudes avoids the -2^31 / -1 overflow corner.
   assign a_neg = MDOp == 3'd2 && A[31];
   assign b_neg = MDOp == 3'd2 && B[31];
   assign a_mag = a_neg ? -A : A;
   assign b_mag = b_neg ? -B : B;
   assign b_div = B == 32'd0 ? 32'd1 : b_mag;
   assign q_mag = a_mag / b_div;
   assign r_mag = a_mag % b_div;
   assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem   = a_neg ? -r_mag : r_mag;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         res_hi <= '0;
         res_lo <= '0;
         res_ok <= 1'b0;
         HI     <= '0;
         LO     <= '0;
      end else if (state == IDLE) begin
         if (accept && MDOp[2:1] == 2'b00) begin
            state            <= MULT;
            cnt              <= CW'(MULT_CYC);
            {res_hi, res_lo} <= prod;
            res_ok           <= 1'b1;
         end else if (accept && MDOp[2:1] == 2'b01) begin
            state  <= DIV;
            cnt    <= CW'(DIV_CYC);
            res_hi <= rem;
            res_lo <= quot;
            res_ok <= B != 32'd0;
         end else if (accept && MDOp == 3'd4) begin
            HI <= A;
         end else if (accept && MDOp == 3'd5) begin
            LO <= A;
         end
      end else begin
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            state <= IDLE;
            if (res_ok) begin
               HI <= res_hi;
               LO <= res_lo;
            end
         end
      end
   end
endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 SHALL provide parameters: MULT_CYC, default 5, busy cycles for mult/multu; DIV_CYC, default 10, busy cycles for div/divu.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Start  input  1  E-stage MD instruction valid this cycle.
REQ-005 SHALL have port MDOp  input  3  op code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 treated as no-op.
REQ-006 SHALL have port A  input  32  rs operand (forwarded E-stage value).
REQ-007 SHALL have port B  input  32  rt operand (forwarded E-stage value).
REQ-008 SHALL have port Req  input  1  exception/interrupt flush of the E-stage instruction this cycle.
REQ-009 SHALL have port MD_D  input  1  D-stage instruction is any MD-class op (mult/div/mthi/mtlo/mfhi/mflo).
REQ-010 SHALL have port Busy  output  1  unit occupied by multi-cycle op.
REQ-011 SHALL have port Stall_MD  output  1  D-stage stall request, combinational.
REQ-012 SHALL have port HI  output  32  HI register.
REQ-013 SHALL have port LO  output  32  LO register.

Function
REQ-014 SHALL implement states IDLE, MULT, DIV with a down-counter of at least 4 bits.
REQ-015 Accept condition: state IDLE && Start && !Req; anything else SHALL leave state, HI, LO unchanged.
REQ-016 Accept of mult/multu (cycle T) SHALL latch the 64-bit product (signed/unsigned), load counter with MULT_CYC, go to MULT.
REQ-017 Accept of div/divu (cycle T) SHALL latch quotient and remainder (signed/unsigned), load counter with DIV_CYC, go to DIV.
REQ-018 Busy SHALL be 1 exactly in cycles T+1..T+N (N = MULT_CYC or DIV_CYC), 0 otherwise.
REQ-019 At the edge ending cycle T+N, state SHALL return to IDLE and HI/LO SHALL load the latched result; new values visible in T+N+1.
REQ-020 Mult result: {HI,LO} = full 64-bit product.
REQ-021 Div result: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-023 Divide by zero (B=0) SHALL run full DIV_CYC busy period and leave HI and LO unchanged.
REQ-024 Accept of mthi/mtlo SHALL write A to HI/LO at the next edge, no Busy, state stays IDLE.
REQ-025 Start while Busy=1 SHALL be ignored (pipeline stall guarantees it does not occur; no corruption if it does).
REQ-026 Req during Busy SHALL NOT abort the running op; it completes and commits.
REQ-027 Stall_MD = MD_D && (Busy || (Start && !Req && MDOp in {0,1,2,3})).
REQ-028 Back-to-back: a new op accepted in cycle T+N+1 SHALL be legal and start normally.

Reset
REQ-029 reset=1 SHALL asynchronously force state IDLE, counter 0, Busy 0, HI 0, LO 0; Stall_MD then follows REQ-027 with Busy=0.
REQ-030 reset asserted mid-operation SHALL discard the pending result; HI/LO remain 0 after release.
REQ-031 First accept SHALL be possible in the first clock cycle after reset deasserts.

Verification
REQ-032 mult A=0xFFFFFFFF B=0x00000002 at T -> Busy 1 for T+1..T+5; at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 div A=0xFFFFFFF9 (-7) B=2 -> Busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1.
REQ-034 divu A=5 B=0 with HI=0x11, LO=0x22 preset via mthi/mtlo -> Busy 10 cycles, HI=0x11, LO=0x22 afterward.
REQ-035 Start=1, MDOp=mult, Req=1 -> Busy stays 0, HI/LO unchanged; Stall_MD=0 with MD_D=1.
REQ-036 MD_D=1 held during div busy -> Stall_MD=1 for T..T+10 (including accept cycle), 0 at T+11; mtlo A=0x5 accepted at T+11 -> LO=0x5 at T+12.
REQ-037 reset pulsed at T+3 of a mult -> Busy 0, HI=LO=0 immediately and after release; no late result write.
